// File: rtl/uart_rx_var_baud.sv
// ============================================================================
// Module   : uart_rx_var_baud
// Function : 8N1 UART receiver with a runtime baud divisor, break handling and
//            an optional even-parity bit (enabled by macro UART_RX_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_var_baud #(
  parameter int CNT_W    = 32,
  parameter int MIN_CLKS = 4
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Rx_Serial,
  input  logic [CNT_W-1:0] i_Clks_Per_Bit,
  output logic             o_Rx_DV,
  output logic [7:0]       o_Rx_Byte,
  output logic             o_Frame_Err,
`ifdef UART_RX_PARITY_EN
  output logic             o_Parity_Err,
`endif
  output logic             o_Busy
);

  localparam logic [2:0]       c_LAST_BIT = 3'd7;
  localparam logic [CNT_W-1:0] c_MIN_DIV  = CNT_W'(MIN_CLKS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_BREAK  = 3'd4
  } state_t;

  state_t           r_state, w_state_nx;
  logic             r_rx_m, r_rx_s;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [CNT_W-1:0] r_div, w_div_nx;
  logic [2:0]       r_idx, w_idx_nx;
  logic [7:0]       r_shift, w_shift_nx;
  logic [7:0]       r_byte, w_byte_nx;
  logic             r_dv, w_dv_nx;
  logic             r_fe, w_fe_nx;
`ifdef UART_RX_PARITY_EN
  logic             r_par, w_par_nx;
  logic             r_pe, w_pe_nx;
`endif

  logic [CNT_W-1:0] w_div_clamped;
  logic [CNT_W-1:0] w_half_m1;
  logic [CNT_W-1:0] w_full_m1;

  assign w_div_clamped = (i_Clks_Per_Bit < c_MIN_DIV) ? c_MIN_DIV : i_Clks_Per_Bit;
  assign w_half_m1     = (r_div >> 1) - 1'b1;
  assign w_full_m1     = r_div - 1'b1;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_rx_m  <= 1'b1;
      r_rx_s  <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_byte  <= '0;
      r_dv    <= 1'b0;
      r_fe    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_pe    <= 1'b0;
`endif
    end else begin
      r_rx_m  <= i_Rx_Serial;
      r_rx_s  <= r_rx_m;
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_div   <= w_div_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
      r_byte  <= w_byte_nx;
      r_dv    <= w_dv_nx;
      r_fe    <= w_fe_nx;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nx;
      r_pe    <= w_pe_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 1'b1;
    w_div_nx   = r_div;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_byte_nx  = r_byte;
    w_dv_nx    = 1'b0;
    w_fe_nx    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nx   = r_par;
    w_pe_nx    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (!r_rx_s) begin
          w_div_nx   = w_div_clamped;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        // A start bit that is gone by mid-bit is line noise, not a frame.
        if (r_cnt == w_half_m1) begin
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
          w_state_nx = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == w_full_m1) begin
          w_cnt_nx          = '0;
          w_shift_nx[r_idx] = r_rx_s;
          if (r_idx == c_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            w_state_nx = S_PARITY;
`else
            w_state_nx = S_STOP;
`endif
          end else begin
            w_idx_nx = r_idx + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_cnt == w_full_m1) begin
          w_cnt_nx   = '0;
          w_par_nx   = r_rx_s;
          w_state_nx = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Leave at mid-stop so an immediately following start bit is caught.
        if (r_cnt == w_full_m1) begin
          w_cnt_nx = '0;
          if (r_rx_s) begin
            w_state_nx = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{r_shift, r_par}) begin
              w_pe_nx = 1'b1;
            end else begin
              w_byte_nx = r_shift;
              w_dv_nx   = 1'b1;
            end
`else
            w_byte_nx = r_shift;
            w_dv_nx   = 1'b1;
`endif
          end else begin
            w_fe_nx    = 1'b1;
            w_state_nx = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        w_cnt_nx = '0;
        if (r_rx_s) begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_cnt_nx   = '0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign o_Rx_DV      = r_dv;
  assign o_Rx_Byte    = r_byte;
  assign o_Frame_Err  = r_fe;
  assign o_Busy       = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = r_pe;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_var_baud.sv
// ============================================================================
// Module   : tb_uart_rx_var_baud
// Function : Directed scoreboard bench for uart_rx_var_baud.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_var_baud;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             i_Reset = 1'b1;
  logic             i_Rx_Serial = 1'b1;
  logic [CNT_W-1:0] i_Clks_Per_Bit = 32'd8;
  logic             o_Rx_DV;
  logic [7:0]       o_Rx_Byte;
  logic             o_Frame_Err;
  logic             o_Busy;
`ifdef UART_RX_PARITY_EN
  logic             o_Parity_Err;
`endif

  always #5 clk = ~clk;

  uart_rx_var_baud #(.CNT_W(CNT_W), .MIN_CLKS(4)) dut (
    .i_Clk          (clk),
    .i_Reset        (i_Reset),
    .i_Rx_Serial    (i_Rx_Serial),
    .i_Clks_Per_Bit (i_Clks_Per_Bit),
    .o_Rx_DV        (o_Rx_DV),
    .o_Rx_Byte      (o_Rx_Byte),
    .o_Frame_Err    (o_Frame_Err),
`ifdef UART_RX_PARITY_EN
    .o_Parity_Err   (o_Parity_Err),
`endif
    .o_Busy         (o_Busy)
  );

  logic [7:0] q_exp[$];
  logic [7:0] q_obs[$];
  int n_checks = 0;
  int n_err    = 0;

  // Monitor: records every strobe and protocol anomaly seen on the outputs.
  int fe_cnt = 0, pe_cnt = 0, dv_wide = 0, dv_fe_overlap = 0, busy_bad = 0;
  logic prev_dv = 1'b0, prev_busy = 1'b0;
  always @(negedge clk) begin
    if (o_Rx_DV) begin
      q_obs.push_back(o_Rx_Byte);
      if (prev_dv) dv_wide++;
      if (o_Busy || !prev_busy) busy_bad++;
      if (o_Frame_Err) dv_fe_overlap++;
    end
    if (o_Frame_Err) fe_cnt++;
`ifdef UART_RX_PARITY_EN
    if (o_Parity_Err) pe_cnt++;
`endif
    prev_dv   = o_Rx_DV;
    prev_busy = o_Busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int n);
    i_Rx_Serial = v;
    cycles(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input logic stop,
                            input logic par_en, input logic par,
                            input logic [CNT_W-1:0] mid_div);
    drive_bit(1'b0, n);
    i_Clks_Per_Bit = mid_div;
    for (int i = 0; i < 8; i++) drive_bit(d[i], n);
    if (par_en) drive_bit(par, n);
    drive_bit(stop, n);
  endtask

  task automatic expect_byte(input string tag, input int budget);
    int k = 0;
    logic [7:0] e, o;
    while (q_obs.size() == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_dv_seen"}, (q_obs.size() != 0) ? 32'd1 : 32'd0, 32'd1);
    if (q_obs.size() != 0 && q_exp.size() != 0) begin
      e = q_exp.pop_front();
      o = q_obs.pop_front();
      check({tag, "_byte"}, {24'd0, o}, {24'd0, e});
    end
  endtask

  initial begin
    int fe0;
    cycles(3);
    check("rst_dv",   {31'd0, o_Rx_DV},     32'd0);
    check("rst_byte", {24'd0, o_Rx_Byte},   32'd0);
    check("rst_fe",   {31'd0, o_Frame_Err}, 32'd0);
    check("rst_busy", {31'd0, o_Busy},      32'd0);
    i_Reset = 1'b0;
    cycles(5);

    // 0xA5 at divisor 8
    i_Clks_Per_Bit = 32'd8;
    q_exp.push_back(8'hA5);
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 32'd8);
    expect_byte("a5", 40);
    check("a5_fe", fe_cnt, 32'd0);
    cycles(10);

    // Framing error followed by a held-low break
    fe0 = fe_cnt;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 32'd8);
    drive_bit(1'b0, 40);
    check("brk_busy", {31'd0, o_Busy}, 32'd1);
    check("brk_fe_once", fe_cnt - fe0, 32'd1);
    i_Rx_Serial = 1'b1;
    cycles(6);
    check("brk_busy_clr", {31'd0, o_Busy}, 32'd0);
    check("brk_byte_kept", {24'd0, o_Rx_Byte}, 32'hA5);
    check("brk_no_dv", q_obs.size(), 32'd0);

    // Glitch on the line: start rejected silently
    i_Clks_Per_Bit = 32'd16;
    fe0 = fe_cnt;
    drive_bit(1'b0, 2);
    i_Rx_Serial = 1'b1;
    cycles(2);
    check("gl_busy_hi", {31'd0, o_Busy}, 32'd1);
    cycles(10);
    check("gl_busy_lo", {31'd0, o_Busy}, 32'd0);
    check("gl_no_fe", fe_cnt - fe0, 32'd0);
    check("gl_no_dv", q_obs.size(), 32'd0);

    // Reset in the middle of 0x81 data bits
    i_Clks_Per_Bit = 32'd8;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 20);
    i_Reset = 1'b1;
    i_Rx_Serial = 1'b1;
    cycles(2);
    i_Reset = 1'b0;
    cycles(100);
    check("abort_no_dv", q_obs.size(), 32'd0);
    check("abort_byte", {24'd0, o_Rx_Byte}, 32'd0);
    check("abort_busy", {31'd0, o_Busy}, 32'd0);

    // 0x42 at 8 clocks/bit with the divisor input switched to 16 mid-frame
    q_exp.push_back(8'h42);
    send_frame(8'h42, 8, 1'b1, 1'b0, 1'b0, 32'd16);
    expect_byte("div_chg", 40);
    cycles(10);

    // Divisor below the minimum is clamped to 4
    i_Clks_Per_Bit = 32'd2;
    q_exp.push_back(8'h3C);
    send_frame(8'h3C, 4, 1'b1, 1'b0, 1'b0, 32'd2);
    expect_byte("clamp", 20);
    cycles(10);

    // Back-to-back frames at divisor 217
    i_Clks_Per_Bit = 32'd217;
    q_exp.push_back(8'h00);
    q_exp.push_back(8'hFF);
    send_frame(8'h00, 217, 1'b1, 1'b0, 1'b0, 32'd217);
    send_frame(8'hFF, 217, 1'b1, 1'b0, 1'b0, 32'd217);
    expect_byte("b2b0", 400);
    expect_byte("b2b1", 400);
    cycles(10);

`ifdef UART_RX_PARITY_EN
    i_Clks_Per_Bit = 32'd8;
    q_exp.push_back(8'h03);
    send_frame(8'h03, 8, 1'b1, 1'b1, 1'b0, 32'd8);
    expect_byte("par_ok", 40);
    cycles(10);
    send_frame(8'h03, 8, 1'b1, 1'b1, 1'b1, 32'd8);
    cycles(10);
    check("par_err_cnt", pe_cnt, 32'd1);
    check("par_no_dv", q_obs.size(), 32'd0);
    check("par_byte_kept", {24'd0, o_Rx_Byte}, 32'h03);
`endif

    check("dv_one_cycle", dv_wide, 32'd0);
    check("dv_fe_exclusive", dv_fe_overlap, 32'd0);
    check("busy_falls_with_dv", busy_bad, 32'd0);
    check("scoreboard_empty", q_exp.size() + q_obs.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
